// File: rtl/demux3_stream.sv
// rtl/demux3_stream.sv - registered 1-to-3 valid/ready stream demultiplexer
//
// Purpose:
//   Steers each beat of one valid/ready input stream into one of three
//   independent output channels, selected by in_sel. Each channel owns a
//   one-entry holding register. A stalled consumer therefore only blocks
//   beats addressed to its own channel. A beat with in_sel = 2'b11 is always
//   accepted, is discarded, and raises a one-cycle registered bad_sel pulse.
//
// Optional feature (compile-time macro DEMUX3_ERR_CNT_EN):
//   When defined, adds the 8-bit err_cnt output. It counts accepted
//   in_sel = 2'b11 beats and saturates at 8'hFF.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input beat present
//   in_ready   out  input beat accepted when in_valid && in_ready
//                   (combinational; does not depend on in_valid)
//   in_data    in   input payload [DATA_WIDTH]
//   in_sel     in   destination: 0 -> ch0, 1 -> ch1, 2 -> ch2, 3 -> invalid
//   out_valid  out  per-channel valid, bit k is channel k
//   out_ready  in   per-channel consumer ready
//   out_data0  out  channel 0 payload
//   out_data1  out  channel 1 payload
//   out_data2  out  channel 2 payload
//   bad_sel    out  registered one-cycle pulse per accepted invalid beat
//   err_cnt    out  saturating invalid-beat count (DEMUX3_ERR_CNT_EN only)

module demux3_stream #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_sel,
    output logic [2:0]            out_valid,
    input  logic [2:0]            out_ready,
    output logic [DATA_WIDTH-1:0] out_data0,
    output logic [DATA_WIDTH-1:0] out_data1,
    output logic [DATA_WIDTH-1:0] out_data2,
    output logic                  bad_sel
`ifdef DEMUX3_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    localparam logic [1:0] SEL_BAD = 2'b11;

    // Per-channel holding register state.
    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_t;

    ch_state_t             state_q [3];
    ch_state_t             state_d [3];
    logic [DATA_WIDTH-1:0] data_q  [3];

    logic       accept;
    logic [2:0] load;
    logic       bad_accept;

    // A channel can take a beat when it is empty, or when it is full and
    // drains on the same edge. That second case keeps one beat per cycle
    // flowing per channel. The invalid destination never back-pressures.
    always_comb begin
        in_ready = 1'b1;
        case (in_sel)
            2'b00:   in_ready = (state_q[0] == CH_EMPTY) || out_ready[0];
            2'b01:   in_ready = (state_q[1] == CH_EMPTY) || out_ready[1];
            2'b10:   in_ready = (state_q[2] == CH_EMPTY) || out_ready[2];
            default: in_ready = 1'b1;
        endcase
    end

    always_comb begin
        accept     = in_valid && in_ready;
        bad_accept = accept && (in_sel == SEL_BAD);
        load       = '0;
        for (int k = 0; k < 3; k++) begin
            load[k] = accept && (in_sel == 2'(k));
        end
    end

    // State register: channel state, payload and the bad_sel pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= CH_EMPTY;
                data_q[k]  <= '0;
            end
            bad_sel <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= state_d[k];
                // Payload only changes on a load. A drain leaves stale data
                // behind, and a stall holds it stable.
                if (load[k]) begin
                    data_q[k] <= in_data;
                end
            end
            bad_sel <= bad_accept;
        end
    end

    // Next-state logic. A load to a full channel can only happen when that
    // channel also drains, because in_ready is low otherwise. So a load
    // always ends up FULL.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
                CH_EMPTY: begin
                    if (load[k]) begin
                        state_d[k] = CH_FULL;
                    end
                end
                CH_FULL: begin
                    if (load[k]) begin
                        state_d[k] = CH_FULL;
                    end else if (out_ready[k]) begin
                        state_d[k] = CH_EMPTY;
                    end
                end
                default: state_d[k] = CH_EMPTY;
            endcase
        end
    end

    // Output logic.
    always_comb begin
        out_valid = '0;
        for (int k = 0; k < 3; k++) begin
            out_valid[k] = (state_q[k] == CH_FULL);
        end
        out_data0 = data_q[0];
        out_data1 = data_q[1];
        out_data2 = data_q[2];
    end

`ifdef DEMUX3_ERR_CNT_EN
    // Saturating count of discarded beats. It sticks at 8'hFF rather than
    // wrapping, so a flood of errors can never read back as a small number.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (bad_accept && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: doc/demux3_stream.md
Name: demux3_stream

Overview:
- Registered 1-to-3 demultiplexer: the inverse direction of the 3:1 select mux in the datapath.
- Takes one valid/ready input stream carrying a 2-bit destination select and steers each beat into one of three independent output channels.
- Each output channel has its own one-entry holding register with valid/ready, so a stalled consumer blocks only beats addressed to it.
- Used to fan out a shared result/response bus (e.g. memory read data) to up to three consumers.

Parameters:
- DATA_WIDTH, 32, payload width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when in_valid && in_ready.
- in_data  input  DATA_WIDTH  input payload.
- in_sel  input  2  destination: 2'b00 -> ch0, 2'b01 -> ch1, 2'b10 -> ch2, 2'b11 -> invalid.
- out_valid  output  3  per-channel valid; bit k belongs to channel k.
- out_ready  input  3  per-channel consumer ready.
- out_data0  output  DATA_WIDTH  channel 0 payload.
- out_data1  output  DATA_WIDTH  channel 1 payload.
- out_data2  output  DATA_WIDTH  channel 2 payload.
- bad_sel  output  1  one-cycle pulse, registered, when a beat with in_sel=2'b11 is accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=3'b000, out_data0/1/2='0, bad_sel=0.
  - Optional counter cleared to 0.
  - Values hold until the first rising clk edge after rst_n deasserts.
- Per-channel state: EMPTY (out_valid[k]=0) or FULL (out_valid[k]=1); channels are fully independent.
- in_ready is combinational from in_sel, out_valid and out_ready:
  - in_sel=k (k=0..2): in_ready = !out_valid[k] || out_ready[k].
  - in_sel=2'b11: in_ready=1. The beat is always accepted and discarded.
  - in_ready must not depend on in_valid.
- Accept with in_sel=k at edge N: out_data_k <= in_data, out_valid[k] <= 1.
  - Data is visible after edge N, i.e. latency is 1 cycle.
- Drain: if out_valid[k] && out_ready[k] and there is no load to channel k in the same cycle, then out_valid[k] <= 0 and out_data_k holds its stale value.
- Simultaneous drain and load on channel k: out_valid[k] stays 1 and out_data_k takes the new beat. This gives full throughput of 1 beat/cycle per channel.
- FULL and !out_ready[k]: out_data_k and out_valid[k] are held stable (no change while stalled). An input beat addressed to k is back-pressured; beats to other channels still flow.
- Invalid select: accepting a beat with in_sel=2'b11 sets bad_sel=1 for exactly the next cycle. No channel state changes.
- Back-to-back invalid beats hold bad_sel high on consecutive cycles.
- in_valid=0: no state change apart from drains; bad_sel=0.
- Reset mid-operation: any held beats are lost and all outputs return to their reset values immediately. No partial-state recovery.
- Ordering is guaranteed per channel only. There is no ordering relationship across channels.

Optional Feature:
- DEMUX3_ERR_CNT_EN:
  - Defined: adds output port err_cnt, 8 bits, wide.
  - err_cnt increments on every accepted in_sel=2'b11 beat and saturates at 8'hFF (no wrap).
  - Reset value is 0.
  - Not defined: the port and counter do not exist; bad_sel behaviour is unchanged.

Test Plan:
- Reset, then in_valid=1, in_sel=2'b01, in_data=32'hDEADBEEF for one cycle, with out_ready=3'b111 -> the next cycle shows out_valid=3'b010 and out_data1=32'hDEADBEEF; out_valid=3'b000 one cycle later.
- Stall: out_ready[0]=0, two beats to ch0 (32'h1, 32'h2) -> the first is accepted; in_ready=0 for the second; out_data0 holds 32'h1. Raise out_ready[0] -> the second is accepted on that edge and out_data0=32'h2 with out_valid[0] continuously 1.
- Independence: ch2 stalled and full, then beats to ch0 (32'hA) and ch1 (32'hB) -> both accepted with in_ready=1; out_data0=32'hA and out_data1=32'hB appear 1 cycle after each acceptance; out_data2 unchanged.
- Streaming: 8 consecutive beats 0..7 to ch1 with out_ready[1]=1 -> in_ready is always 1 and out_data1 shows 0..7 on consecutive cycles, each 1 cycle late.
- Invalid select: 3 beats with in_sel=2'b11 -> in_ready=1 and bad_sel is high for 3 cycles; out_valid stays 3'b000. With DEMUX3_ERR_CNT_EN, err_cnt=3; after 300 invalid beats err_cnt=8'hFF.
- Async reset: assert rst_n=0 mid-cycle while out_valid=3'b111 -> out_valid=3'b000, out_data='0 and bad_sel=0 before the next clk edge.
